lab2_sequencer: RTL and testbench

LAB2_SEQUENCER -- requirements
Module: lab2_sequencer

---
 rtl/lab2_sequencer_if.sv | 35 +++
 rtl/lab2_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lab2_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lab2_sequencer_if.sv
// lab2_sequencer_if: bundles the sequencer's control/status and stimulus/response
// signals.
//   start     : request one full 8-vector sweep
//   a, b, c   : stimulus to the unit under test ({a,b,c} = vector index)
//   x, y      : response from the unit under test
//   busy      : sweep in progress
//   done      : sweep complete, results valid until next accepted start
//   results   : captured {x,y} for vector i in bits [2i+1:2i]
//   pass/fail : golden comparison verdict
//   fail_idx  : index of the first mismatching vector
// master = sequencer side, slave = environment / unit-under-test side.
interface lab2_sequencer_if;
  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        x;
  logic        y;
  logic        busy;
  logic        done;
  logic [15:0] results;
  logic        pass;
  logic        fail;
  logic [2:0]  fail_idx;

  modport master (
    input  start, x, y,
    output a, b, c, busy, done, results, pass, fail, fail_idx
  );

  modport slave (
    output start, x, y,
    input  a, b, c, busy, done, results, pass, fail, fail_idx
  );
endinterface

// File: rtl/lab2_sequencer.sv
// lab2_sequencer: drives all 8 input vectors {a,b,c} to a 3-input combinational
// unit, holds each for DWELL cycles, samples {x,y} on the last cycle of each
// vector and optionally compares the captured table against EXPECTED.
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : lab2_sequencer_if.master (start, a/b/c, x/y, busy, done,
//             results, pass, fail, fail_idx)
// Optional feature: define LAB2_SEQ_COMPARE_EN to enable golden comparison;
// without it pass/fail/fail_idx are tied to 0 and EXPECTED is unused.
module lab2_sequencer #(
  parameter int unsigned DWELL    = 10,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input logic              clk,
  input logic              rst_n,
  lab2_sequencer_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [IDX_W-1:0]   abc_q, abc_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [RES_W-1:0]   results_q, results_nxt;
  logic               last_sample_c;

  // Last cycle of the current vector's dwell window
  assign last_sample_c = (cnt_q == CNT_W'(DWELL - 1));

`ifdef LAB2_SEQ_COMPARE_EN
  logic               pass_q, pass_nxt;
  logic               fail_q, fail_nxt;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_nxt;
  logic               mismatch_c;

  // Current sample disagrees with the golden pair for this vector
  assign mismatch_c = ({bus.x, bus.y} != EXPECTED[{idx_q, 1'b0} +: 2]);
`else
  logic               unused_expected;
  assign unused_expected = ^EXPECTED;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state_q;
    idx_nxt      = idx_q;
    cnt_nxt      = cnt_q;
    abc_nxt      = 3'b000;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    results_nxt  = results_q;
`ifdef LAB2_SEQ_COMPARE_EN
    pass_nxt     = pass_q;
    fail_nxt     = fail_q;
    fail_idx_nxt = fail_idx_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        done_nxt = (state_q == DONE);
        if (bus.start) begin
          state_nxt    = RUN;
          idx_nxt      = 3'd0;
          cnt_nxt      = 8'd0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          results_nxt  = 16'h0000;
`ifdef LAB2_SEQ_COMPARE_EN
          pass_nxt     = 1'b0;
          fail_nxt     = 1'b0;
          fail_idx_nxt = 3'd0;
`endif
        end
      end
      RUN: begin
        busy_nxt = 1'b1;
        abc_nxt  = idx_q;
        if (last_sample_c) begin
          results_nxt[{idx_q, 1'b0} +: 2] = {bus.x, bus.y};
`ifdef LAB2_SEQ_COMPARE_EN
          // Only the first mismatch is latched; fail stays sticky
          if (mismatch_c && !fail_q) begin
            fail_nxt     = 1'b1;
            fail_idx_nxt = idx_q;
          end
`endif
          cnt_nxt = 8'd0;
          if (idx_q == 3'd7) begin
            // No wrap: idx stays at 7 until the next accepted start
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            abc_nxt   = 3'b000;
`ifdef LAB2_SEQ_COMPARE_EN
            pass_nxt  = !fail_nxt;
`endif
          end else begin
            idx_nxt = idx_q + 3'd1;
            abc_nxt = idx_q + 3'd1;
          end
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 8'd0;
      abc_q      <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      results_q  <= 16'h0000;
`ifdef LAB2_SEQ_COMPARE_EN
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_nxt;
      idx_q      <= idx_nxt;
      cnt_q      <= cnt_nxt;
      abc_q      <= abc_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      results_q  <= results_nxt;
`ifdef LAB2_SEQ_COMPARE_EN
      pass_q     <= pass_nxt;
      fail_q     <= fail_nxt;
      fail_idx_q <= fail_idx_nxt;
`endif
    end
  end

  assign bus.a       = abc_q[2];
  assign bus.b       = abc_q[1];
  assign bus.c       = abc_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.results = results_q;
`ifdef LAB2_SEQ_COMPARE_EN
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.fail_idx = fail_idx_q;
`else
  assign bus.pass     = 1'b0;
  assign bus.fail     = 1'b0;
  assign bus.fail_idx = 3'd0;
`endif

endmodule

// File: tb/tb_lab2_sequencer.sv
// tb_lab2_sequencer: directed bench for lab2_sequencer. Two instances share
// clock, reset and start; each drives its own model unit (x=a^b^c,
// y=a&b|c). dut0 has EXPECTED equal to the model table, dut1 has vector 5's
// golden pair altered.
module tb_lab2_sequencer;

  localparam int          DW        = 10;
  localparam logic [15:0] GOLD      = 16'hD66C;
  localparam logic [15:0] GOLD_BAD  = 16'hD26C;

  logic clk;
  logic rst_n;
  logic start_r;
  int   n_vec;
  int   n_err;

  lab2_sequencer_if if0 ();
  lab2_sequencer_if if1 ();

  assign if0.start = start_r;
  assign if1.start = start_r;
  assign if0.x = if0.a ^ if0.b ^ if0.c;
  assign if0.y = (if0.a & if0.b) | if0.c;
  assign if1.x = if1.a ^ if1.b ^ if1.c;
  assign if1.y = (if1.a & if1.b) | if1.c;

  lab2_sequencer #(.DWELL(DW), .EXPECTED(GOLD)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  lab2_sequencer #(.DWELL(DW), .EXPECTED(GOLD_BAD)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_table();
    logic [15:0] t;
    logic [2:0]  v;
    t = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      t[2*i +: 2] = {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | v[0]};
    end
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep; start is re-pulsed during RUN cycle extra_start (ignored).
  task automatic run_sweep(input int extra_start);
    logic        exp_pass0;
    logic        exp_fail1;
    logic [2:0]  exp_fidx1;
    logic [15:0] tbl;
    tbl = model_table();
`ifdef LAB2_SEQ_COMPARE_EN
    exp_pass0 = 1'b1;
    exp_fail1 = 1'b1;
    exp_fidx1 = 3'd5;
`else
    exp_pass0 = 1'b0;
    exp_fail1 = 1'b0;
    exp_fidx1 = 3'd0;
`endif
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int k = 0; k < 8 * DW; k++) begin
      n_vec++;
      if (if0.busy !== 1'b1 || {if0.a, if0.b, if0.c} !== 3'(k / DW) || if0.done !== 1'b0) begin
        n_err++;
        $display("FAIL run_cycle%0d: busy=%b abc=%b done=%b, required busy=1 abc=%b done=0",
                 k, if0.busy, {if0.a, if0.b, if0.c}, if0.done, 3'(k / DW));
      end
      if (k == 0) begin
        n_vec++;
        if (if0.results !== 16'h0000 || if1.fail !== 1'b0 || if0.pass !== 1'b0) begin
          n_err++;
          $display("FAIL start_clear: results=%h fail1=%b pass0=%b, required 0000 0 0",
                   if0.results, if1.fail, if0.pass);
        end
      end
      if (k == extra_start) start_r = 1'b1;
      step();
      start_r = 1'b0;
    end
    n_vec++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b1 || {if0.a, if0.b, if0.c} !== 3'b000) begin
      n_err++;
      $display("FAIL sweep_end: busy=%b done=%b abc=%b, required 0 1 000",
               if0.busy, if0.done, {if0.a, if0.b, if0.c});
    end
    n_vec++;
    if (if0.results !== tbl || if1.results !== tbl) begin
      n_err++;
      $display("FAIL results: dut0=%h dut1=%h, required %h", if0.results, if1.results, tbl);
    end
    n_vec++;
    if (if0.pass !== exp_pass0 || if0.fail !== 1'b0 || if0.fail_idx !== 3'd0) begin
      n_err++;
      $display("FAIL verdict_match: pass=%b fail=%b fidx=%0d, required %b 0 0",
               if0.pass, if0.fail, if0.fail_idx, exp_pass0);
    end
    n_vec++;
    if (if1.pass !== 1'b0 || if1.fail !== exp_fail1 || if1.fail_idx !== exp_fidx1) begin
      n_err++;
      $display("FAIL verdict_mismatch: pass=%b fail=%b fidx=%0d, required 0 %b %0d",
               if1.pass, if1.fail, if1.fail_idx, exp_fail1, exp_fidx1);
    end
    step();
    n_vec++;
    if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.results !== tbl) begin
      n_err++;
      $display("FAIL done_hold: done=%b busy=%b results=%h, required 1 0 %h",
               if0.done, if0.busy, if0.results, tbl);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0 || {if0.a, if0.b, if0.c} !== 3'b000 ||
        if0.results !== 16'h0000 || if0.pass !== 1'b0 || if0.fail !== 1'b0 ||
        if0.fail_idx !== 3'd0) begin
      n_err++;
      $display("FAIL %s_dut0: busy=%b done=%b abc=%b results=%h pass=%b fail=%b fidx=%0d, required all 0",
               tag, if0.busy, if0.done, {if0.a, if0.b, if0.c}, if0.results,
               if0.pass, if0.fail, if0.fail_idx);
    end
    n_vec++;
    if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.results !== 16'h0000 ||
        if1.fail !== 1'b0 || if1.fail_idx !== 3'd0) begin
      n_err++;
      $display("FAIL %s_dut1: busy=%b done=%b results=%h fail=%b fidx=%0d, required all 0",
               tag, if1.busy, if1.done, if1.results, if1.fail, if1.fail_idx);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step();
      n_vec++;
      if (if0.busy !== 1'b0 || if0.done !== 1'b0 || {if0.a, if0.b, if0.c} !== 3'b000) begin
        n_err++;
        $display("FAIL %s_idle%0d: busy=%b done=%b abc=%b, required 0 0 000",
                 tag, k, if0.busy, if0.done, {if0.a, if0.b, if0.c});
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_r = 1'b0;
    #2;
    check_all_zero("reset_async");
    step();
    step();
    rst_n = 1'b1;
    check_idle("post_reset", 5);
  endtask

  task automatic test_sweep();
    run_sweep(-1);
  endtask

  task automatic test_start_ignored();
    run_sweep(30);
  endtask

  task automatic test_start_last_sample();
    run_sweep(8 * DW - 1);
  endtask

  task automatic test_reset_mid();
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int k = 0; k < 45; k++) step();
    n_vec++;
    if (if0.busy !== 1'b1 || {if0.a, if0.b, if0.c} !== 3'd4) begin
      n_err++;
      $display("FAIL mid_sweep: busy=%b abc=%b, required 1 100", if0.busy, {if0.a, if0.b, if0.c});
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    step();
    rst_n = 1'b1;
    check_idle("after_mid_reset", 20);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_r = 1'b0;
    test_reset();
    test_sweep();
    test_start_ignored();
    test_start_last_sample();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
